// File: rtl/inter_pkg.sv
// Shared types and constants for the 3-master/2-slave interconnect slice.
package inter_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 3;

    // Slave endpoint states
    typedef enum logic [1:0] {
        S_COOL  = 2'd0,
        S_READY = 2'd1,
        S_ACK   = 2'd2
    } slave_state_t;

    // Master-select encodings used by the interconnect arbiter
    typedef enum logic [1:0] {
        MSEL_NONE = 2'd0,
        MSEL_M0   = 2'd1,
        MSEL_M1   = 2'd2,
        MSEL_M2   = 2'd3
    } msel_t;

endpackage

// File: rtl/slave_regfile.sv
// 8x3 register file: one write port, one registered read port, sync clear.
module slave_regfile
    import inter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read; a same-cycle read sees the old entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inter_slave.sv
// Slave endpoint: accepts writes, paces traffic with cooldown, checks handshake.
module inter_slave
    import inter_pkg::*;
#(
    parameter int BUSY_CYC   = 2,
    parameter int HS_TIMEOUT = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] value_in,
    input  logic              handshake_in,
    output logic              ready_out,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_pulse,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              hs_err
);

    localparam int CNT_MAX = (BUSY_CYC > HS_TIMEOUT) ? BUSY_CYC : HS_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    slave_state_t     state_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             wr_pulse_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic             hs_err_q;
    logic             accept;

    // Only a cycle that already shows ready high can take a write
    assign accept = valid_in && ready_q;

    // Slave FSM, cooldown/timeout counter, write counter and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_COOL;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_cnt_q   <= '0;
            hs_err_q   <= 1'b0;
        end else begin
            wr_pulse_q <= 1'b0;
            case (state_q)
                S_COOL: begin
                    if (handshake_in) begin
                        hs_err_q <= 1'b1;
                    end
                    if (cnt_q == CW'(BUSY_CYC - 1)) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_READY: begin
                    if (handshake_in) begin
                        hs_err_q <= 1'b1;
                    end
                    if (accept) begin
                        wr_pulse_q <= 1'b1;
                        if (wr_cnt_q != '1) begin
                            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                        end
                        state_q <= S_ACK;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_ACK: begin
                    if (handshake_in) begin
                        state_q <= S_COOL;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(HS_TIMEOUT - 1)) begin
                        hs_err_q <= 1'b1;
                        state_q  <= S_COOL;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_COOL;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    slave_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept),
        .waddr_i (addr_in),
        .wdata_i (value_in),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign ready_out = ready_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_cnt    = wr_cnt_q;
    assign hs_err    = hs_err_q;

endmodule

// File: tb/tb_inter_slave.sv
// Directed testbench for inter_slave.
module tb_inter_slave;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic [2:0] addr_in;
    logic [2:0] value_in;
    logic       handshake_in;
    logic       ready_out;
    logic [2:0] rd_addr;
    logic [2:0] rd_data;
    logic       wr_pulse;
    logic [7:0] wr_cnt;
    logic       hs_err;

    int unsigned n_tests;
    int unsigned n_fail;

    inter_slave #(
        .BUSY_CYC   (2),
        .HS_TIMEOUT (4),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .addr_in      (addr_in),
        .value_in     (value_in),
        .handshake_in (handshake_in),
        .ready_out    (ready_out),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_pulse     (wr_pulse),
        .wr_cnt       (wr_cnt),
        .hs_err       (hs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; valid_in = 1'b0; addr_in = '0; value_in = '0;
        handshake_in = 1'b0; rd_addr = '0;

        // Reset values
        tick(); tick(); tick();
        check_eq("rst_ready", ready_out, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_wr_pulse", wr_pulse, 0);
        check_eq("rst_wr_cnt", wr_cnt, 0);
        check_eq("rst_hs_err", hs_err, 0);

        // Cooldown after reset: two cycles low, then ready
        rst = 1'b0;
        tick(); check_eq("cool1_ready", ready_out, 0);
        tick(); check_eq("cool2_ready", ready_out, 1);

        // Ready-first write 5 <= 6, read of 5 issued in the same cycle
        valid_in = 1'b1; addr_in = 3'd5; value_in = 3'd6; rd_addr = 3'd5;
        tick();
        check_eq("w1_pulse", wr_pulse, 1);
        check_eq("w1_cnt", wr_cnt, 1);
        check_eq("w1_ready_ack", ready_out, 0);
        check_eq("w1_rd_old", rd_data, 0);
        // valid lingers one cycle, handshake arrives 1 cycle after accept
        handshake_in = 1'b1;
        tick();
        check_eq("w1_pulse_off", wr_pulse, 0);
        check_eq("w1_cnt_once", wr_cnt, 1);
        check_eq("w1_rd_new", rd_data, 6);
        check_eq("w1_ready_c1", ready_out, 0);
        check_eq("w1_hs_err", hs_err, 0);

        // Pending-valid write 2 <= 3 held during cooldown
        handshake_in = 1'b0; valid_in = 1'b1; addr_in = 3'd2; value_in = 3'd3;
        tick();
        check_eq("w2_cool_ready", ready_out, 0);
        check_eq("w2_cool_pulse", wr_pulse, 0);
        tick();
        check_eq("w2_ready_up", ready_out, 1);
        check_eq("w2_no_early", wr_cnt, 1);
        tick();
        check_eq("w2_pulse", wr_pulse, 1);
        check_eq("w2_cnt", wr_cnt, 2);
        check_eq("w2_ready_ack", ready_out, 0);
        tick();  // valid still high, ready low: no write
        check_eq("w2_pulse_off", wr_pulse, 0);
        check_eq("w2_cnt_once", wr_cnt, 2);
        valid_in = 1'b0; handshake_in = 1'b1; rd_addr = 3'd2;
        tick();  // handshake 2 cycles after accept
        check_eq("w2_hs_err", hs_err, 0);
        check_eq("w2_ready_c", ready_out, 0);
        handshake_in = 1'b0;
        tick();
        check_eq("w2_rd", rd_data, 3);
        check_eq("w2_ready_c2", ready_out, 0);
        tick();
        check_eq("w2_ready_back", ready_out, 1);

        // Handshake timeout: write 7 <= 4, no handshake
        valid_in = 1'b1; addr_in = 3'd7; value_in = 3'd4;
        tick();
        check_eq("to_cnt", wr_cnt, 3);
        valid_in = 1'b0;
        tick(); tick(); tick();
        check_eq("to_err_before", hs_err, 0);
        check_eq("to_ready_ack", ready_out, 0);
        tick();
        check_eq("to_err_set", hs_err, 1);
        check_eq("to_ready_cool", ready_out, 0);
        tick();
        check_eq("to_ready_cool2", ready_out, 0);
        tick();
        check_eq("to_ready_back", ready_out, 1);
        check_eq("to_err_sticky", hs_err, 1);

        // Reset one cycle after an accept in S_ACK
        valid_in = 1'b1; addr_in = 3'd1; value_in = 3'd5; rd_addr = 3'd5;
        tick();
        check_eq("mr_cnt", wr_cnt, 4);
        valid_in = 1'b0; rst = 1'b1;
        tick();
        check_eq("mr_wr_cnt", wr_cnt, 0);
        check_eq("mr_hs_err", hs_err, 0);
        check_eq("mr_ready", ready_out, 0);
        check_eq("mr_rd", rd_data, 0);
        rst = 1'b0; rd_addr = 3'd2;
        tick();
        check_eq("mr_cool1", ready_out, 0);
        check_eq("mr_rf2_clear", rd_data, 0);
        rd_addr = 3'd1;
        tick();
        check_eq("mr_cool2", ready_out, 1);
        check_eq("mr_rf1_clear", rd_data, 0);

        // Spurious handshake in S_READY
        handshake_in = 1'b1;
        tick();
        check_eq("sp_err", hs_err, 1);
        check_eq("sp_ready", ready_out, 1);
        handshake_in = 1'b0; valid_in = 1'b1; addr_in = 3'd3; value_in = 3'd7; rd_addr = 3'd3;
        tick();
        check_eq("sp_pulse", wr_pulse, 1);
        check_eq("sp_cnt", wr_cnt, 1);
        valid_in = 1'b0; handshake_in = 1'b1;
        tick();
        check_eq("sp_rd", rd_data, 7);
        check_eq("sp_err_sticky", hs_err, 1);
        handshake_in = 1'b0;
        tick();
        check_eq("sp_ready_cool", ready_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
